// File: rtl/msu_fill_ctrl.sv
// MSU fill controller: follows data-seek / audio-start requests from the MSU
// status word, streams fetched file data into the two-half ring buffer ahead
// of the SNES read pointer, and sequences status set/reset updates.
module msu_fill_ctrl #(
    parameter int HALF_AW   = 13,
    parameter int STAT_HOLD = 3
) (
    input  logic               clkin,
    input  logic               rst,
    input  logic [7:0]         status_in,
    input  logic [31:0]        seek_addr_in,
    input  logic [HALF_AW:0]   msu_rd_addr,
    output logic               fill_req,
    output logic [31:0]        fill_addr,
    input  logic [7:0]         src_data,
    input  logic               src_valid,
    output logic               src_ready,
    output logic [HALF_AW:0]   pgm_address,
    output logic [7:0]         pgm_data,
    output logic               pgm_we,
    output logic [HALF_AW:0]   msu_address_ext,
    output logic               msu_address_ext_write,
    output logic [5:0]         status_set_bits,
    output logic [5:0]         status_reset_bits,
    output logic               status_reset_we,
    output logic               audio_req,
    input  logic               audio_done,
    input  logic               audio_err
);

    localparam int CW = $clog2(STAT_HOLD + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_REQ,
        ST_FILL,
        ST_DONE_HALF,
        ST_WAIT
    } state_t;

    // Fill FSM state
    state_t             state_q;
    logic               seek_cnt_q;
    logic [HALF_AW:0]   wp_q;
    logic [31:0]        fetched_q;
    logic [31:0]        seek_base_q;
    logic               first_half_q;
    logic               prefill_q;
    logic               fill_req_q;
    logic [31:0]        fill_addr_q;
    logic               src_ready_q;
    logic [HALF_AW:0]   pgm_address_q;
    logic [7:0]         pgm_data_q;
    logic               pgm_we_q;
    logic               ext_write_q;

    // Edge detectors and audio handshake
    logic               data_prev_q;
    logic               audio_prev_q;
    logic               audio_req_q;

    // Status update unit
    logic               data_pend_q;
    logic               audio_pend_q;
    logic               audio_err_pend_q;
    logic               upd_busy_q;
    logic [CW-1:0]      upd_cnt_q;
    logic [5:0]         set_bits_q;
    logic [5:0]         reset_bits_q;
    logic               upd_we_q;

    logic data_edge;
    logic audio_edge;
    logic beat;
    logic half_last;
    logic data_upd_evt;
    logic audio_evt;
    logic unused_bits;

    assign data_edge    = status_in[5] & ~data_prev_q;
    assign audio_edge   = status_in[6] & ~audio_prev_q;
    assign beat         = src_valid & src_ready_q;
    assign half_last    = &wp_q[HALF_AW-1:0];
    assign data_upd_evt = (state_q == ST_DONE_HALF) && first_half_q;
    assign audio_evt    = audio_done & audio_req_q;

    // Only the half-select bit of the read pointer matters to the refill decision.
    assign unused_bits = ^{status_in[7], status_in[4:0], msu_rd_addr[HALF_AW-1:0]};

    // Registered copies of the start bits for rising-edge detection
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            data_prev_q  <= 1'b0;
            audio_prev_q <= 1'b0;
        end else begin
            data_prev_q  <= status_in[5];
            audio_prev_q <= status_in[6];
        end
    end

    // Fill FSM: a data_start edge overrides whatever the FSM is doing
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            seek_cnt_q    <= 1'b0;
            wp_q          <= '0;
            fetched_q     <= '0;
            seek_base_q   <= '0;
            first_half_q  <= 1'b0;
            prefill_q     <= 1'b0;
            fill_req_q    <= 1'b0;
            fill_addr_q   <= '0;
            src_ready_q   <= 1'b0;
            pgm_address_q <= '0;
            pgm_data_q    <= '0;
            pgm_we_q      <= 1'b1;
            ext_write_q   <= 1'b0;
        end else begin
            fill_req_q <= 1'b0;
            pgm_we_q   <= 1'b1;
            if (data_edge) begin
                // Abort any fill in progress; the byte offered this cycle is discarded.
                state_q      <= ST_SEEK;
                seek_cnt_q   <= 1'b0;
                wp_q         <= '0;
                fetched_q    <= '0;
                seek_base_q  <= seek_addr_in;
                first_half_q <= 1'b1;
                prefill_q    <= 1'b0;
                src_ready_q  <= 1'b0;
                ext_write_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_SEEK: begin
                        // Pointer reload strobe spans exactly the two SEEK cycles.
                        if (!seek_cnt_q) begin
                            seek_cnt_q <= 1'b1;
                        end else begin
                            ext_write_q <= 1'b0;
                            state_q     <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        fill_req_q  <= 1'b1;
                        fill_addr_q <= seek_base_q + fetched_q;
                        src_ready_q <= 1'b1;
                        state_q     <= ST_FILL;
                    end
                    ST_FILL: begin
                        if (beat) begin
                            pgm_address_q <= wp_q;
                            pgm_data_q    <= src_data;
                            pgm_we_q      <= 1'b0;
                            wp_q          <= wp_q + 1'b1;
                            fetched_q     <= fetched_q + 32'd1;
                            if (half_last) begin
                                // Drop ready together with the last byte so no extra beat slips in.
                                src_ready_q <= 1'b0;
                                state_q     <= ST_DONE_HALF;
                            end
                        end
                    end
                    ST_DONE_HALF: begin
                        prefill_q    <= first_half_q;
                        first_half_q <= 1'b0;
                        state_q      <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        // Refill once the reader has moved out of the half we would overwrite.
                        if (prefill_q || (msu_rd_addr[HALF_AW] != wp_q[HALF_AW])) begin
                            prefill_q <= 1'b0;
                            state_q   <= ST_REQ;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Audio request level: raised by an audio_start edge, dropped on audio_done
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            audio_req_q <= 1'b0;
        end else if (audio_evt) begin
            audio_req_q <= 1'b0;
        end else if (audio_edge) begin
            audio_req_q <= 1'b1;
        end
    end

    // Status update sequencer: one update at a time, data source ahead of audio
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            data_pend_q      <= 1'b0;
            audio_pend_q     <= 1'b0;
            audio_err_pend_q <= 1'b0;
            upd_busy_q       <= 1'b0;
            upd_cnt_q        <= '0;
            set_bits_q       <= '0;
            reset_bits_q     <= '0;
            upd_we_q         <= 1'b0;
        end else begin
            if (!upd_busy_q) begin
                if (data_pend_q) begin
                    set_bits_q   <= 6'b000000;
                    reset_bits_q <= 6'b010000;
                    upd_we_q     <= 1'b1;
                    upd_busy_q   <= 1'b1;
                    upd_cnt_q    <= '0;
                    data_pend_q  <= 1'b0;
                end else if (audio_pend_q) begin
                    set_bits_q   <= {2'b00, audio_err_pend_q, 3'b000};
                    reset_bits_q <= {2'b10, ~audio_err_pend_q, 3'b000};
                    upd_we_q     <= 1'b1;
                    upd_busy_q   <= 1'b1;
                    upd_cnt_q    <= '0;
                    audio_pend_q <= 1'b0;
                end
            end else begin
                // Strobe for two cycles, bits for STAT_HOLD cycles, then an idle cycle.
                upd_cnt_q <= upd_cnt_q + CW'(1);
                if (upd_cnt_q == CW'(1)) begin
                    upd_we_q <= 1'b0;
                end
                if (upd_cnt_q == CW'(STAT_HOLD - 1)) begin
                    set_bits_q   <= '0;
                    reset_bits_q <= '0;
                end
                if (upd_cnt_q == CW'(STAT_HOLD)) begin
                    upd_busy_q <= 1'b0;
                end
            end
            // New events are recorded after the load so a same-cycle event is never lost.
            if (data_upd_evt) begin
                data_pend_q <= 1'b1;
            end else if (data_edge) begin
                data_pend_q <= 1'b0;
            end
            if (audio_evt) begin
                audio_pend_q     <= 1'b1;
                audio_err_pend_q <= audio_err;
            end
        end
    end

    assign fill_req              = fill_req_q;
    assign fill_addr             = fill_addr_q;
    assign src_ready             = src_ready_q;
    assign pgm_address           = pgm_address_q;
    assign pgm_data              = pgm_data_q;
    assign pgm_we                = pgm_we_q;
    assign msu_address_ext       = '0;
    assign msu_address_ext_write = ext_write_q;
    assign status_set_bits       = set_bits_q;
    assign status_reset_bits     = reset_bits_q;
    assign status_reset_we       = upd_we_q;
    assign audio_req             = audio_req_q;

endmodule

// File: tb/tb_msu_fill_ctrl.sv
// Scoreboard bench for msu_fill_ctrl: stimulus pushes expected writes, fill
// requests, pointer reloads and status updates; negedge monitors pop and compare.
module tb_msu_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  status_in;
    logic [31:0] seek_addr_in;
    logic [13:0] msu_rd_addr;
    logic        fill_req;
    logic [31:0] fill_addr;
    logic [7:0]  src_data;
    logic        src_valid;
    logic        src_ready;
    logic [13:0] pgm_address;
    logic [7:0]  pgm_data;
    logic        pgm_we;
    logic [13:0] msu_address_ext;
    logic        msu_address_ext_write;
    logic [5:0]  status_set_bits;
    logic [5:0]  status_reset_bits;
    logic        status_reset_we;
    logic        audio_req;
    logic        audio_done;
    logic        audio_err;

    always #5 clk = ~clk;

    msu_fill_ctrl #(.HALF_AW(13), .STAT_HOLD(3)) dut (
        .clkin                 (clk),
        .rst                   (rst),
        .status_in             (status_in),
        .seek_addr_in          (seek_addr_in),
        .msu_rd_addr           (msu_rd_addr),
        .fill_req              (fill_req),
        .fill_addr             (fill_addr),
        .src_data              (src_data),
        .src_valid             (src_valid),
        .src_ready             (src_ready),
        .pgm_address           (pgm_address),
        .pgm_data              (pgm_data),
        .pgm_we                (pgm_we),
        .msu_address_ext       (msu_address_ext),
        .msu_address_ext_write (msu_address_ext_write),
        .status_set_bits       (status_set_bits),
        .status_reset_bits     (status_reset_bits),
        .status_reset_we       (status_reset_we),
        .audio_req             (audio_req),
        .audio_done            (audio_done),
        .audio_err             (audio_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [21:0] wr_q[$];
    logic [31:0] fill_q[$];
    logic [11:0] stat_q[$];
    int          ext_q[$];
    int          fill_seen = 0;

    function automatic logic [7:0] fdat(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event, got 0x%0h, expected none", name, act);
    endtask

    // Buffer write monitor
    logic [21:0] wr_exp;
    always @(negedge clk) begin
        if (rst === 1'b0 && pgm_we === 1'b0) begin
            if (wr_q.size() == 0) begin
                unexpected("pgm_write", {10'd0, pgm_address, pgm_data});
            end else begin
                wr_exp = wr_q.pop_front();
                check("pgm_write", {10'd0, pgm_address, pgm_data}, {10'd0, wr_exp});
            end
        end
    end

    // Fill request monitor
    always @(negedge clk) begin
        if (rst === 1'b0 && fill_req === 1'b1) begin
            fill_seen++;
            if (fill_q.size() == 0) unexpected("fill_addr", fill_addr);
            else check("fill_addr", fill_addr, fill_q.pop_front());
            $display("fill_req fill_addr=0x%08h", fill_addr);
        end
    end

    // Read-pointer reload monitor
    int ext_len = 0;
    int ext_exp = 2;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (msu_address_ext_write === 1'b1) begin
                if (ext_len == 0) begin
                    if (ext_q.size() == 0) begin
                        unexpected("ext_write", {18'd0, msu_address_ext});
                        ext_exp = 2;
                    end else begin
                        ext_exp = ext_q.pop_front();
                    end
                    check("ext_addr", {18'd0, msu_address_ext}, 32'd0);
                end
                ext_len++;
            end else if (ext_len != 0) begin
                check("ext_write_len", ext_len, ext_exp);
                $display("ext_write addr=0x%04h cycles=%0d", msu_address_ext, ext_len);
                ext_len = 0;
            end
        end
    end

    // Status update monitor: bits, strobe length, hold length, idle gap
    logic [11:0] st_cur;
    logic [11:0] st_prev = 12'd0;
    logic        we_prev = 1'b0;
    int          st_hold = 0;
    int          st_we = 0;
    bit          st_in = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (status_reset_we === 1'b1 && we_prev === 1'b0) begin
                check("stat_gap", {20'd0, st_prev}, 32'd0);
                if (stat_q.size() == 0) unexpected("stat_bits", {20'd0, status_set_bits, status_reset_bits});
                else check("stat_bits", {20'd0, status_set_bits, status_reset_bits}, {20'd0, stat_q.pop_front()});
                st_cur  = {status_set_bits, status_reset_bits};
                st_hold = 1;
                st_we   = 1;
                st_in   = 1'b1;
            end else if (st_in) begin
                if ({status_set_bits, status_reset_bits} == st_cur) begin
                    st_hold++;
                    if (status_reset_we === 1'b1) st_we++;
                end else begin
                    st_in = 1'b0;
                    check("stat_hold", st_hold, 3);
                    check("stat_we_len", st_we, 2);
                    $display("status update set=0x%02h reset=0x%02h hold=%0d we=%0d",
                             st_cur[11:6], st_cur[5:0], st_hold, st_we);
                end
            end
            we_prev = status_reset_we;
            st_prev = {status_set_bits, status_reset_bits};
        end
    end

    // Fetch-engine model: serves nbytes of file data starting at faddr; valid
    // toggles every other cycle once tog_from bytes have been sent.
    task automatic serve(input logic [31:0] faddr, input logic [13:0] waddr,
                         input int nbytes, input int tog_from, output int wait_cyc);
        int i;
        int cyc;
        fill_q.push_back(faddr);
        for (int k = 0; k < nbytes; k++) begin
            wr_q.push_back({waddr + 14'(k), fdat(faddr + 32'(k))});
        end
        i = 0;
        cyc = 0;
        wait_cyc = -1;
        while (i < nbytes && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (src_ready === 1'b1 && wait_cyc < 0) wait_cyc = cyc;
            if (src_ready === 1'b1 && (i < tog_from || cyc[0] == 1'b1)) begin
                src_valid = 1'b1;
                src_data  = fdat(faddr + 32'(i));
                i++;
            end else begin
                src_valid = 1'b0;
            end
        end
        @(negedge clk);
        src_valid = 1'b0;
        if (i < nbytes) begin
            n_cmp++;
            n_bad++;
            $display("FAIL serve_timeout: sent %0d bytes, expected %0d", i, nbytes);
        end
        $display("served fill 0x%08h: %0d bytes at buffer 0x%04h", faddr, i, waddr);
    endtask

    int w;
    int snap;
    localparam int NO_TOG = 1 << 30;

    initial begin
        rst = 1'b1;
        status_in = 8'h00;
        seek_addr_in = 32'h0;
        msu_rd_addr = 14'h0100;
        src_data = 8'h00;
        src_valid = 1'b0;
        audio_done = 1'b0;
        audio_err = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_pgm_we", {31'd0, pgm_we}, 32'd1);
        check("rst_fill_req", {31'd0, fill_req}, 32'd0);
        check("rst_src_ready", {31'd0, src_ready}, 32'd0);
        check("rst_ext_write", {31'd0, msu_address_ext_write}, 32'd0);
        check("rst_stat", {19'd0, status_reset_we, status_set_bits, status_reset_bits}, 32'd0);
        check("rst_audio_req", {31'd0, audio_req}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Seek to 0x12000: first half, busy-clear update, immediate prefill
        ext_q.push_back(2);
        seek_addr_in = 32'h0001_2000;
        status_in[5] = 1'b1;
        serve(32'h0001_2000, 14'h0000, 8192, NO_TOG, w);
        stat_q.push_back({6'h00, 6'h10});
        serve(32'h0001_4000, 14'h2000, 8192, NO_TOG, w);
        check("prefill_no_wait", {31'd0, (w > 0 && w <= 8)}, 32'd1);
        status_in[5] = 1'b0;

        // Reader still in the half about to be overwritten: no refill
        snap = fill_seen;
        repeat (50) @(negedge clk);
        check("no_fill_reader_in_half", fill_seen, snap);
        check("no_ready_reader_in_half", {31'd0, src_ready}, 32'd0);
        msu_rd_addr = 14'h2000;
        serve(32'h0001_6000, 14'h0000, 8192, NO_TOG, w);

        // Audio start, repeated start, done with error, stray done
        status_in[6] = 1'b1;
        @(negedge clk);
        check("audio_req_set", {31'd0, audio_req}, 32'd1);
        status_in[6] = 1'b0;
        @(negedge clk);
        status_in[6] = 1'b1;
        @(negedge clk);
        check("audio_req_held", {31'd0, audio_req}, 32'd1);
        stat_q.push_back({6'h08, 6'h20});
        audio_err = 1'b1;
        audio_done = 1'b1;
        @(negedge clk);
        audio_done = 1'b0;
        audio_err = 1'b0;
        check("audio_req_clear", {31'd0, audio_req}, 32'd0);
        repeat (10) @(negedge clk);
        audio_done = 1'b1;
        @(negedge clk);
        audio_done = 1'b0;
        repeat (10) @(negedge clk);
        check("audio_stray_done", {31'd0, audio_req}, 32'd0);
        status_in[6] = 1'b0;
        @(negedge clk);
        status_in[6] = 1'b1;
        @(negedge clk);
        check("audio_req_rearm", {31'd0, audio_req}, 32'd1);

        // Seek aborted at byte 3000 by a second seek
        ext_q.push_back(2);
        seek_addr_in = 32'h0010_0000;
        status_in[5] = 1'b1;
        serve(32'h0010_0000, 14'h0000, 3000, NO_TOG, w);
        status_in[5] = 1'b0;
        @(negedge clk);
        ext_q.push_back(2);
        seek_addr_in = 32'h0020_0000;
        status_in[5] = 1'b1;
        @(negedge clk);
        check("abort_src_ready_low", {31'd0, src_ready}, 32'd0);

        // New seek's half completes in the same cycle audio_done is seen
        serve(32'h0020_0000, 14'h0000, 8192, NO_TOG, w);
        stat_q.push_back({6'h00, 6'h10});
        stat_q.push_back({6'h00, 6'h28});
        audio_done = 1'b1;
        @(negedge clk);
        audio_done = 1'b0;
        status_in[5] = 1'b0;

        // Prefill crossing 16383 -> 0 with valid toggling, then next half
        serve(32'h0020_2000, 14'h2000, 8192, 8184, w);
        serve(32'h0020_4000, 14'h0000, 16, 0, w);
        repeat (30) @(negedge clk);

        check("wr_q_empty", wr_q.size(), 0);
        check("fill_q_empty", fill_q.size(), 0);
        check("stat_q_empty", stat_q.size(), 0);
        check("ext_q_empty", ext_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/msu_fill_ctrl.md
Name: msu_fill_ctrl

Overview:
- MCU-side counterpart of the SNES-facing MSU register block.
- Watches the MSU status word for data-seek and audio-start requests.
- Streams file data from the SD fetch engine into the 16 KiB MSU data buffer as a two-half ring, staying ahead of the SNES read pointer.
- Drives the status set/reset handshake that clears busy flags and reports audio errors.

Parameters:
- HALF_AW, 13, log2 of ring-half size in bytes; the buffer is 2^(HALF_AW+1) bytes and all address ports are HALF_AW+1 bits wide.
- STAT_HOLD, 3, cycles the status bits are held stable per update; minimum 3.

Ports:
- clkin  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- status_in  in  8  MSU status word: [6]=audio_start, [5]=data_start
- seek_addr_in  in  32  MSU seek byte address, valid when data_start rises
- msu_rd_addr  in  14  current SNES read pointer into the buffer
- fill_req  out  1  one-cycle pulse requesting 2^HALF_AW bytes starting at fill_addr
- fill_addr  out  32  file byte address of the requested half
- src_data  in  8  fetched byte
- src_valid  in  1  src_data valid
- src_ready  out  1  block accepts the byte this cycle
- pgm_address  out  14  buffer write address
- pgm_data  out  8  buffer write data
- pgm_we  out  1  buffer write strobe, active-low
- msu_address_ext  out  14  read-pointer reload value
- msu_address_ext_write  out  1  read-pointer reload strobe
- status_set_bits  out  6  status bits to set
- status_reset_bits  out  6  status bits to clear
- status_reset_we  out  1  status update strobe
- audio_req  out  1  level: audio track start pending toward MCU
- audio_done  in  1  one-cycle pulse: MCU finished audio start
- audio_err  in  1  qualifies audio_done: track missing

Behaviour:
- Reset values: all outputs 0, except pgm_we=1. FSM=IDLE, wp=0, fetched=0, no status update pending.
- Edge detection: status_in[5] and status_in[6] are registered; a 0->1 transition is a start event.
- FSM states:
  - IDLE: wait for a data_start edge.
  - SEEK:
    - wp <= 0, fetched <= 0.
    - msu_address_ext = 0 with msu_address_ext_write high for 2 cycles, then low.
    - Go to REQ.
  - REQ:
    - One-cycle fill_req with fill_addr = seek_addr_in + fetched (32-bit wrap).
    - Go to FILL.
  - FILL:
    - src_ready=1.
    - Each src_valid&src_ready beat: pgm_address=wp, pgm_data=src_data, pgm_we=0 for that one cycle; wp++ and fetched++.
    - When wp[HALF_AW-1:0] wraps to 0 (half complete), go to DONE_HALF.
  - DONE_HALF:
    - The first completed half after a seek queues a status update with reset_bits=6'b010000 (clears data_busy and data_start).
    - Go to WAIT.
  - WAIT:
    - Directly after the first half: go to REQ at once (prefill the second half).
    - Otherwise go to REQ only when msu_rd_addr[13] != wp[13], i.e. the reader has left the half about to be overwritten.
- Ring wrap: wp is 14 bits and wraps 16383->0. fetched is 32 bits and never resets except on seek.
- Seek mid-operation:
  - A new data_start edge in any state aborts the current fill: src_ready drops the next cycle and partial data is discarded.
  - Go to SEEK; the fetcher must drop outstanding bytes on the next fill_req.
  - Only the new seek's first half clears data_busy.
- Status update unit:
  - One update in flight at a time; a one-entry queue per source (data, audio).
  - Data has priority when both are pending.
  - Update sequence: bits driven for STAT_HOLD cycles; status_reset_we high in cycles 0-1 of the window; bits return to 0 after the window.
  - Back-to-back updates are separated by at least 1 idle cycle with status_reset_we low.
- Audio:
  - A status_in[6] edge sets audio_req=1 (independent of the data FSM).
  - On audio_done: audio_req <= 0, and one update is queued: reset_bits=6'b100000; set_bits[3]=audio_err; reset_bits[3]=~audio_err.
  - An audio_done arriving with audio_req=0 is ignored.
  - A new audio_start edge while audio_req=1 keeps audio_req high; no second update is queued.
- rst asserted mid-fill: immediate return to reset values and any pending status update is dropped; the SNES-side busy flags remain set until the next seek.

Test Plan:
- Seek, seek_addr_in=0x00012000 -> two-cycle ext write of 0; fill_req with fill_addr=0x00012000; 8192 pgm writes at 0..8191; status update reset=0x10; second fill_req at fill_addr=0x00014000 with no wait.
- Prefill done, msu_rd_addr held at 0x0100 -> no fill_req. Raise to 0x2000 -> fill_req with fill_addr=0x00016000, writes at 0..8191.
- Seek issued at byte 3000 of the first half -> src_ready low next cycle; new ext write; no 0x10 update until the new seek's half completes.
- Audio start, then audio_done with audio_err=1 -> audio_req falls; update with set=0x08, reset=0x20, status_reset_we high exactly 2 cycles.
- Data-half completion and audio_done in the same cycle -> data update (reset=0x10) first, then >=1 idle cycle, then audio update.
- src_valid toggling every other cycle across wp=16383 -> write at 16383 followed by write at 0; no lost or duplicated byte.
